ft245_sync_tx: RTL
==================

Name: ft245_sync_tx

Overview:
- Transmit-side drain engine. It reads words from a one-clock FIFO and drives the FT245 synchronous-mode write bus toward the USB device.
- FIFO read side: read data appears one cycle after the read strobe and is qualified by rvalid.
- Bus side: a word transfers on every rising edge where both wr_n and txe_n are low.
- A 2-entry skid buffer hides FIFO read latency and txe_n stalls.
- A SIWU flush pulse is issued after the FIFO stays empty for a programmable idle time.

Parameters:
- DATA_W, 8, FIFO and bus data width.
- FLUSH_TMO, 16, idle cycles after the last accepted word before siwu_n is pulsed. 0 disables flushing.
- CNT_W, 32, width of the tx_cnt statistics counter.

Ports:
- clk  in  1  single clock; FIFO and FT245 bus are both synchronous to it.
- rst_n  in  1  asynchronous active-low reset.
- fifo_ren  out  1  FIFO read strobe.
- fifo_rdata  in  DATA_W  FIFO read data; valid when fifo_rvalid=1.
- fifo_rvalid  in  1  high exactly one cycle after an effective fifo_ren.
- fifo_empty  in  1  FIFO empty flag.
- txe_n  in  1  device can accept data when low.
- wr_n  out  1  write strobe, active low.
- data  out  DATA_W  bus write data.
- siwu_n  out  1  send-immediate / flush strobe, active low.
- busy  out  1  engine holds, awaits or is sending data.
- tx_cnt  out  CNT_W  count of accepted words.

Behaviour:
- Reset (async assert, sync deassert by clock edge):
  - skid count cnt=0, inflight=0, state=IDLE, idle counter=0, sent flag=0.
  - Outputs: wr_n=1, siwu_n=1, data=0, tx_cnt=0, busy=0.
  - fifo_ren is forced 0 combinationally while rst_n=0.
- accept = !wr_n && !txe_n, sampled at the rising edge. On accept:
  - pop the head entry;
  - tx_cnt+1, wrapping modulo 2^CNT_W;
  - set the sent flag.
- Read request:
  - fifo_ren = !fifo_empty && (cnt + inflight - accept) < 2, and state != FLUSH.
  - inflight <= fifo_ren, registered.
  - Combinational path txe_n -> fifo_ren is intentional and gives full throughput.
- Capture:
  - When fifo_rvalid=1, fifo_rdata is appended behind the existing entries.
  - Simultaneous append and pop keeps cnt unchanged, and order is preserved.
  - cnt never exceeds 2.
  - fifo_rvalid without a prior fifo_ren is a protocol violation; behaviour is undefined and flagged by an assertion.
- Bus drive:
  - data = head entry; wr_n = !(cnt>0) in IDLE, SEND and WAIT; wr_n=1 in FLUSH.
  - With txe_n high, wr_n stays low and data holds; nothing is popped (stall, no data loss).
- State machine:
  - IDLE: if cnt>0, go to SEND.
  - SEND: when cnt==0, inflight==0 and fifo_empty, go to WAIT if the sent flag is set and FLUSH_TMO>0; otherwise go to IDLE.
  - WAIT: idle counter +1 per cycle.
    - If cnt>0 or inflight, go to SEND and clear the counter.
    - Else, when counter == FLUSH_TMO-1, go to FLUSH.
  - FLUSH: siwu_n=0 for exactly one cycle; clear the sent flag and the counter; go to IDLE.
- Latency: first fifo_ren on cycle N, fifo_rvalid on cycle N+1, wr_n low from cycle N+2.
- Steady-state throughput is 1 word/cycle while txe_n stays low and the FIFO stays non-empty.
- busy = (state != IDLE) || cnt>0 || inflight.
- Reset mid-transfer: buffered words are discarded; wr_n goes to 1 immediately, asynchronously.

Test Plan:
1. Reset: rst_n=0 with fifo_empty=0 -> fifo_ren=0, wr_n=1, siwu_n=1, data=0, tx_cnt=0 while reset is held.
2. Streaming: FIFO holds 0x01..0x10, txe_n=0 constant.
   - wr_n low 2 cycles after the first fifo_ren.
   - 16 consecutive accepts in order 0x01..0x10; tx_cnt=16.
3. Backpressure:
   - txe_n=1 for 5 cycles in mid-stream -> data held, no pop, cnt=2, fifo_ren=0.
   - Release txe_n -> no word lost or duplicated.
4. Flush, FLUSH_TMO=4: after the last accept, the FIFO stays empty -> exactly one siwu_n=0 pulse 4 cycles after WAIT entry; no further pulse while idle.
5. Flush abort: a new FIFO word arrives at WAIT cycle 2 -> return to SEND, no siwu_n pulse, word sent.
6. Reset mid-stream with cnt=2 -> wr_n=1 asynchronously; after release, the next word sent is the next FIFO word.

Source files
------------

// File: rtl/ft245_sync_tx.sv
// FT245 synchronous-mode transmit engine: drains a one-cycle-latency FIFO into
// the device write bus through a 2-entry skid buffer, with idle-timeout SIWU flush.
module ft245_sync_tx #(
  parameter int DATA_W    = 8,
  parameter int FLUSH_TMO = 16,
  parameter int CNT_W     = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              fifo_ren_o,
  input  logic [DATA_W-1:0] fifo_rdata_i,
  input  logic              fifo_rvalid_i,
  input  logic              fifo_empty_i,
  input  logic              txe_n_i,
  output logic              wr_n_o,
  output logic [DATA_W-1:0] data_o,
  output logic              siwu_n_o,
  output logic              busy_o,
  output logic [CNT_W-1:0]  tx_cnt_o
);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT, S_FLUSH} state_t;

  localparam int TMO_W    = (FLUSH_TMO > 2) ? $clog2(FLUSH_TMO) : 1;
  localparam int TMO_LAST = (FLUSH_TMO > 0) ? FLUSH_TMO - 1 : 0;
  localparam bit FLUSH_EN = (FLUSH_TMO > 0);

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [1:0]         cnt_q, cnt_d;
  logic               inflight_q;
  logic [TMO_W-1:0]   idle_q, idle_d;
  logic               sent_q, sent_d;
  logic [CNT_W-1:0]   tx_cnt_q, tx_cnt_d;

  logic               has_data;
  logic               accept;
  logic [1:0]         occ;

  assign has_data = (cnt_q != 2'd0);
  assign wr_n_o   = (state_q == S_FLUSH) || !has_data;
  assign accept   = !wr_n_o && !txe_n_i;
  // Words held or already requested, less the one leaving this edge; caps the skid at 2.
  assign occ      = cnt_q + {1'b0, inflight_q} - {1'b0, accept};

  assign fifo_ren_o = rst_n && !fifo_empty_i && (occ < 2'd2) && (state_q != S_FLUSH);
  assign data_o     = head_q;
  assign siwu_n_o   = (state_q != S_FLUSH);
  assign busy_o     = (state_q != S_IDLE) || has_data || inflight_q;
  assign tx_cnt_o   = tx_cnt_q;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    head_d   = head_q;
    tail_d   = tail_q;
    cnt_d    = cnt_q;
    tx_cnt_d = tx_cnt_q + (accept ? CNT_W'(1) : CNT_W'(0));
    unique case ({fifo_rvalid_i, accept})
      2'b10: begin
        if (cnt_q == 2'd0) head_d = fifo_rdata_i;
        else               tail_d = fifo_rdata_i;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        head_d = tail_q;
        cnt_d  = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd1) begin
          head_d = fifo_rdata_i;
        end else begin
          head_d = tail_q;
          tail_d = fifo_rdata_i;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    idle_d  = idle_q;
    sent_d  = sent_q | accept;
    unique case (state_q)
      S_IDLE: if (has_data) state_d = S_SEND;
      S_SEND: begin
        if (!has_data && !inflight_q && fifo_empty_i)
          state_d = (sent_q && FLUSH_EN) ? S_WAIT : S_IDLE;
      end
      S_WAIT: begin
        if (has_data || inflight_q) begin
          state_d = S_SEND;
          idle_d  = '0;
        end else if (idle_q == TMO_W'(TMO_LAST)) begin
          state_d = S_FLUSH;
        end else begin
          idle_d = idle_q + TMO_W'(1);
        end
      end
      S_FLUSH: begin
        sent_d  = 1'b0;
        idle_d  = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: the skid entries are reset too, so the bus shows zero data out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      head_q     <= '0;
      tail_q     <= '0;
      cnt_q      <= 2'd0;
      inflight_q <= 1'b0;
      idle_q     <= '0;
      sent_q     <= 1'b0;
      tx_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      cnt_q      <= cnt_d;
      inflight_q <= fifo_ren_o;
      idle_q     <= idle_d;
      sent_q     <= sent_d;
      tx_cnt_q   <= tx_cnt_d;
    end
  end

  // Read data must only ever answer a strobe issued the cycle before.
  a_rvalid_requested: assert property (@(posedge clk) disable iff (!rst_n)
    fifo_rvalid_i |-> inflight_q);

endmodule
